// File: rtl/pn_buf_ctrl_if.sv
// Agent-side handshake bundle for pn_buf_ctrl.
// The master modport is the snooper/CPU/forwarder side; the slave modport is the controller.
interface pn_buf_ctrl_if #(
    parameter int N_BUFS     = 3,
    parameter int PLEN_WIDTH = 32,
    parameter int INC_WIDTH  = 8
);
    localparam int SEL_WIDTH = $clog2(N_BUFS);

    logic                  sn_wr_en;
    logic [INC_WIDTH-1:0]  sn_byte_inc;
    logic                  sn_done;
    logic                  sn_done_ack;
    logic                  rdy_for_sn;
    logic                  rdy_for_sn_ack;
    logic [SEL_WIDTH-1:0]  sn_sel;

    logic                  rdy_for_cpu;
    logic                  rdy_for_cpu_ack;
    logic [SEL_WIDTH-1:0]  cpu_sel;
    logic                  cpu_acc;
    logic                  cpu_rej;
    logic                  cpu_done_ack;
    logic [PLEN_WIDTH-1:0] cpu_byte_len;

    logic                  rdy_for_fwd;
    logic                  rdy_for_fwd_ack;
    logic [SEL_WIDTH-1:0]  fwd_sel;
    logic                  fwd_done;
    logic                  fwd_done_ack;
    logic [PLEN_WIDTH-1:0] fwd_byte_len;

    modport master (
        output sn_wr_en, sn_byte_inc, sn_done, rdy_for_sn_ack,
        output rdy_for_cpu_ack, cpu_acc, cpu_rej,
        output rdy_for_fwd_ack, fwd_done,
        input  sn_done_ack, rdy_for_sn, sn_sel,
        input  rdy_for_cpu, cpu_sel, cpu_done_ack, cpu_byte_len,
        input  rdy_for_fwd, fwd_sel, fwd_done_ack, fwd_byte_len
    );

    modport slave (
        input  sn_wr_en, sn_byte_inc, sn_done, rdy_for_sn_ack,
        input  rdy_for_cpu_ack, cpu_acc, cpu_rej,
        input  rdy_for_fwd_ack, fwd_done,
        output sn_done_ack, rdy_for_sn, sn_sel,
        output rdy_for_cpu, cpu_sel, cpu_done_ack, cpu_byte_len,
        output rdy_for_fwd, fwd_sel, fwd_done_ack, fwd_byte_len
    );
endinterface

// File: rtl/pn_buf_ctrl.sv
// N-way packet buffer ownership controller: snooper -> CPU -> forwarder.
// Define PN_ORDER_EN to serve CPU/forwarder in snoop-completion order instead of lowest index.
//
// state      | meaning
// B_EMPTY    | free, may be offered to the snooper
// B_SN       | owned by the snooper, length accumulating
// B_WAIT_CPU | packet complete, waiting for a CPU claim
// B_CPU      | owned by the CPU awaiting a verdict
// B_WAIT_FWD | accepted, waiting for a forwarder claim
// B_FWD      | owned by the forwarder
module pn_buf_ctrl #(
    parameter int N_BUFS     = 3,
    parameter int PLEN_WIDTH = 32,
    parameter int INC_WIDTH  = 8
) (
    input logic          clk,
    input logic          rst,
    pn_buf_ctrl_if.slave bus
);
    localparam int SEL_WIDTH = $clog2(N_BUFS);

    typedef enum logic [2:0] {
        B_EMPTY, B_SN, B_WAIT_CPU, B_CPU, B_WAIT_FWD, B_FWD
    } buf_state_e;

    buf_state_e            state_q [N_BUFS];
    buf_state_e            state_d [N_BUFS];
    logic [PLEN_WIDTH-1:0] len_q [N_BUFS];
    logic [PLEN_WIDTH-1:0] len_d [N_BUFS];

    logic                  sn_own_q, sn_own_d, cpu_own_q, cpu_own_d, fwd_own_q, fwd_own_d;
    logic                  rdy_sn_q, rdy_sn_d, rdy_cpu_q, rdy_cpu_d, rdy_fwd_q, rdy_fwd_d;
    logic [SEL_WIDTH-1:0]  sn_sel_q, sn_sel_d, cpu_sel_q, cpu_sel_d, fwd_sel_q, fwd_sel_d;
    logic [SEL_WIDTH-1:0]  sn_cand_q, sn_cand_d, cpu_cand_q, cpu_cand_d, fwd_cand_q, fwd_cand_d;
    logic                  sn_done_ack_q, sn_done_ack_d, cpu_done_ack_q, cpu_done_ack_d;
    logic                  fwd_done_ack_q, fwd_done_ack_d;
    logic [PLEN_WIDTH-1:0] cpu_len_q, cpu_len_d, fwd_len_q, fwd_len_d;

    logic                  sn_claim, sn_fin, sn_wr;
    logic                  cpu_claim, cpu_fin, cpu_pass;
    logic                  fwd_claim, fwd_fin;
    logic                  sn_any, cpu_any, fwd_any;
    logic [SEL_WIDTH-1:0]  sn_first, cpu_first, fwd_first;

    // Strobes only count when the agent owns a buffer; acks only while offered.
    assign sn_claim  = rdy_sn_q & bus.rdy_for_sn_ack;
    assign sn_fin    = sn_own_q & bus.sn_done;
    assign sn_wr     = sn_own_q & bus.sn_wr_en;
    assign cpu_claim = rdy_cpu_q & bus.rdy_for_cpu_ack;
    assign cpu_fin   = cpu_own_q & (bus.cpu_acc | bus.cpu_rej);
    assign cpu_pass  = cpu_fin & bus.cpu_acc & ~bus.cpu_rej;
    assign fwd_claim = rdy_fwd_q & bus.rdy_for_fwd_ack;
    assign fwd_fin   = fwd_own_q & bus.fwd_done;

    always_comb begin
        sn_any   = 1'b0;
        sn_first = '0;
        for (int i = N_BUFS - 1; i >= 0; i--) begin
            if (state_q[i] == B_EMPTY) begin
                sn_any   = 1'b1;
                sn_first = SEL_WIDTH'(i);
            end
        end
    end

`ifdef PN_ORDER_EN
    logic [SEL_WIDTH-1:0] cq_mem_q [N_BUFS];
    logic [SEL_WIDTH-1:0] cq_mem_d [N_BUFS];
    logic [SEL_WIDTH-1:0] fq_mem_q [N_BUFS];
    logic [SEL_WIDTH-1:0] fq_mem_d [N_BUFS];
    logic [SEL_WIDTH-1:0] cq_rd_q, cq_rd_d, cq_wr_q, cq_wr_d;
    logic [SEL_WIDTH-1:0] fq_rd_q, fq_rd_d, fq_wr_q, fq_wr_d;
    logic [SEL_WIDTH:0]   cq_cnt_q, cq_cnt_d, fq_cnt_q, fq_cnt_d;

    function automatic logic [SEL_WIDTH-1:0] ptr_inc(input logic [SEL_WIDTH-1:0] p);
        return (p == SEL_WIDTH'(N_BUFS - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        cq_mem_d = cq_mem_q;
        cq_rd_d  = cq_rd_q;
        cq_wr_d  = cq_wr_q;
        fq_mem_d = fq_mem_q;
        fq_rd_d  = fq_rd_q;
        fq_wr_d  = fq_wr_q;
        if (sn_fin) begin
            cq_mem_d[cq_wr_q] = sn_sel_q;
            cq_wr_d           = ptr_inc(cq_wr_q);
        end
        if (cpu_claim) cq_rd_d = ptr_inc(cq_rd_q);
        if (cpu_pass) begin
            fq_mem_d[fq_wr_q] = cpu_sel_q;
            fq_wr_d           = ptr_inc(fq_wr_q);
        end
        if (fwd_claim) fq_rd_d = ptr_inc(fq_rd_q);
        cq_cnt_d = cq_cnt_q + {{SEL_WIDTH{1'b0}}, sn_fin} - {{SEL_WIDTH{1'b0}}, cpu_claim};
        fq_cnt_d = fq_cnt_q + {{SEL_WIDTH{1'b0}}, cpu_pass} - {{SEL_WIDTH{1'b0}}, fwd_claim};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N_BUFS; i++) begin
                cq_mem_q[i] <= '0;
                fq_mem_q[i] <= '0;
            end
            cq_rd_q  <= '0;
            cq_wr_q  <= '0;
            cq_cnt_q <= '0;
            fq_rd_q  <= '0;
            fq_wr_q  <= '0;
            fq_cnt_q <= '0;
        end else begin
            cq_mem_q <= cq_mem_d;
            cq_rd_q  <= cq_rd_d;
            cq_wr_q  <= cq_wr_d;
            cq_cnt_q <= cq_cnt_d;
            fq_mem_q <= fq_mem_d;
            fq_rd_q  <= fq_rd_d;
            fq_wr_q  <= fq_wr_d;
            fq_cnt_q <= fq_cnt_d;
        end
    end

    assign cpu_any   = (cq_cnt_q != '0);
    assign cpu_first = cq_mem_q[cq_rd_q];
    assign fwd_any   = (fq_cnt_q != '0);
    assign fwd_first = fq_mem_q[fq_rd_q];
`else
    always_comb begin
        cpu_any   = 1'b0;
        cpu_first = '0;
        fwd_any   = 1'b0;
        fwd_first = '0;
        for (int i = N_BUFS - 1; i >= 0; i--) begin
            if (state_q[i] == B_WAIT_CPU) begin
                cpu_any   = 1'b1;
                cpu_first = SEL_WIDTH'(i);
            end
            if (state_q[i] == B_WAIT_FWD) begin
                fwd_any   = 1'b1;
                fwd_first = SEL_WIDTH'(i);
            end
        end
    end
`endif

    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        sn_own_d       = sn_own_q;
        cpu_own_d      = cpu_own_q;
        fwd_own_d      = fwd_own_q;
        sn_sel_d       = sn_sel_q;
        cpu_sel_d      = cpu_sel_q;
        fwd_sel_d      = fwd_sel_q;
        cpu_len_d      = cpu_len_q;
        fwd_len_d      = fwd_len_q;
        sn_done_ack_d  = 1'b0;
        cpu_done_ack_d = 1'b0;
        fwd_done_ack_d = 1'b0;

        if (sn_claim) begin
            state_d[sn_cand_q] = B_SN;
            len_d[sn_cand_q]   = '0;
            sn_own_d           = 1'b1;
            sn_sel_d           = sn_cand_q;
        end
        if (sn_wr) len_d[sn_sel_q] = len_q[sn_sel_q] + PLEN_WIDTH'(bus.sn_byte_inc);
        if (sn_fin) begin
            state_d[sn_sel_q] = B_WAIT_CPU;
            sn_own_d          = 1'b0;
            sn_done_ack_d     = 1'b1;
        end

        if (cpu_claim) begin
            state_d[cpu_cand_q] = B_CPU;
            cpu_own_d           = 1'b1;
            cpu_sel_d           = cpu_cand_q;
            cpu_len_d           = len_q[cpu_cand_q];
        end
        if (cpu_fin) begin
            state_d[cpu_sel_q] = cpu_pass ? B_WAIT_FWD : B_EMPTY;
            cpu_own_d          = 1'b0;
            cpu_done_ack_d     = 1'b1;
        end

        if (fwd_claim) begin
            state_d[fwd_cand_q] = B_FWD;
            fwd_own_d           = 1'b1;
            fwd_sel_d           = fwd_cand_q;
            fwd_len_d           = len_q[fwd_cand_q];
        end
        if (fwd_fin) begin
            state_d[fwd_sel_q] = B_EMPTY;
            fwd_own_d          = 1'b0;
            fwd_done_ack_d     = 1'b1;
        end

        // Offers look at the registered state, so a buffer freed this cycle waits one more.
        rdy_sn_d   = ~sn_own_q & ~sn_claim & sn_any;
        rdy_cpu_d  = ~cpu_own_q & ~cpu_claim & cpu_any;
        rdy_fwd_d  = ~fwd_own_q & ~fwd_claim & fwd_any;
        sn_cand_d  = sn_first;
        cpu_cand_d = cpu_first;
        fwd_cand_d = fwd_first;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N_BUFS; i++) begin
                state_q[i] <= B_EMPTY;
                len_q[i]   <= '0;
            end
            sn_own_q       <= 1'b0;
            cpu_own_q      <= 1'b0;
            fwd_own_q      <= 1'b0;
            rdy_sn_q       <= 1'b0;
            rdy_cpu_q      <= 1'b0;
            rdy_fwd_q      <= 1'b0;
            sn_sel_q       <= '0;
            cpu_sel_q      <= '0;
            fwd_sel_q      <= '0;
            sn_cand_q      <= '0;
            cpu_cand_q     <= '0;
            fwd_cand_q     <= '0;
            sn_done_ack_q  <= 1'b0;
            cpu_done_ack_q <= 1'b0;
            fwd_done_ack_q <= 1'b0;
            cpu_len_q      <= '0;
            fwd_len_q      <= '0;
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            sn_own_q       <= sn_own_d;
            cpu_own_q      <= cpu_own_d;
            fwd_own_q      <= fwd_own_d;
            rdy_sn_q       <= rdy_sn_d;
            rdy_cpu_q      <= rdy_cpu_d;
            rdy_fwd_q      <= rdy_fwd_d;
            sn_sel_q       <= sn_sel_d;
            cpu_sel_q      <= cpu_sel_d;
            fwd_sel_q      <= fwd_sel_d;
            sn_cand_q      <= sn_cand_d;
            cpu_cand_q     <= cpu_cand_d;
            fwd_cand_q     <= fwd_cand_d;
            sn_done_ack_q  <= sn_done_ack_d;
            cpu_done_ack_q <= cpu_done_ack_d;
            fwd_done_ack_q <= fwd_done_ack_d;
            cpu_len_q      <= cpu_len_d;
            fwd_len_q      <= fwd_len_d;
        end
    end

    assign bus.rdy_for_sn   = rdy_sn_q;
    assign bus.sn_sel       = sn_sel_q;
    assign bus.sn_done_ack  = sn_done_ack_q;
    assign bus.rdy_for_cpu  = rdy_cpu_q;
    assign bus.cpu_sel      = cpu_sel_q;
    assign bus.cpu_done_ack = cpu_done_ack_q;
    assign bus.cpu_byte_len = cpu_len_q;
    assign bus.rdy_for_fwd  = rdy_fwd_q;
    assign bus.fwd_sel      = fwd_sel_q;
    assign bus.fwd_done_ack = fwd_done_ack_q;
    assign bus.fwd_byte_len = fwd_len_q;
endmodule
